// File: rtl/line_burst_adaptor_pkg.sv
// Shared widths, state encoding and address helper for the line/burst adaptor.
// No ports: imported by the interface and the adaptor.
package line_burst_adaptor_pkg;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int ADDR_W  = 32;
   localparam int BEATS   = LINE_W / BURST_W;
   localparam int OFFS_W  = 5;
   localparam int CNT_W   = $clog2(BEATS);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] OFFS_MASK =
      ADDR_W'((1 << OFFS_W) - 1);

   // Clear the byte offset inside a line.
   function automatic logic [ADDR_W-1:0] line_align(
      input logic [ADDR_W-1:0] a
   );
      return a & ~OFFS_MASK;
   endfunction

endpackage

// File: rtl/line_burst_adaptor_if.sv
// Bundle of the line-side request/response and the memory burst port.
// slave: adaptor view; master: the combined initiator + memory view.
interface line_burst_adaptor_if;
   import line_burst_adaptor_pkg::*;

   logic              read_i;
   logic              write_i;
   logic [ADDR_W-1:0] address_i;
   logic [LINE_W-1:0] line_i;
   logic [LINE_W-1:0] line_o;
   logic              resp_o;

   logic [BURST_W-1:0] burst_i;
   logic [BURST_W-1:0] burst_o;
   logic [ADDR_W-1:0]  address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   modport slave (
      input  read_i, write_i, address_i, line_i,
      input  burst_i, resp_i,
      output line_o, resp_o,
      output burst_o, address_o, read_o, write_o
   );

   modport master (
      output read_i, write_i, address_i, line_i,
      output burst_i, resp_i,
      input  line_o, resp_o,
      input  burst_o, address_o, read_o, write_o
   );

endinterface

// File: rtl/line_burst_adaptor.sv
// Converts one 256-bit line read/write into a 4-beat 64-bit memory burst.
// Ports: clk, rst (sync, active-high), bus (line side + burst side, slave).
module line_burst_adaptor
   import line_burst_adaptor_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   line_burst_adaptor_if.slave  bus
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [LINE_W-1:0]  wbuf;
   logic [LINE_W-1:0]  line;
   logic [ADDR_W-1:0]  addr;
   logic               rd;
   logic               wr;
   logic               resp;

   logic last_beat;
   assign last_beat = (cnt == CNT_W'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         wbuf  <= '0;
         line  <= '0;
         addr  <= '0;
         rd    <= 1'b0;
         wr    <= 1'b0;
         resp  <= 1'b0;
      end else begin
         resp <= 1'b0;
         unique case (state)
            IDLE: begin
               // Write takes priority over a simultaneous read.
               if (bus.write_i) begin
                  addr  <= line_align(bus.address_i);
                  wbuf  <= bus.line_i;
                  cnt   <= '0;
                  wr    <= 1'b1;
                  state <= WRITE;
               end else if (bus.read_i) begin
                  addr  <= line_align(bus.address_i);
                  cnt   <= '0;
                  rd    <= 1'b1;
                  state <= READ;
               end
            end
            READ: begin
               if (bus.resp_i) begin
                  line[int'(cnt)*BURST_W +: BURST_W] <= bus.burst_i;
                  cnt <= cnt + 1'b1;
                  if (last_beat) begin
                     rd    <= 1'b0;
                     resp  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            WRITE: begin
               if (bus.resp_i) begin
                  cnt <= cnt + 1'b1;
                  if (last_beat) begin
                     wr    <= 1'b0;
                     resp  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Beat mux is only live in WRITE so the port idles at zero.
   assign bus.burst_o   = (state == WRITE)
                        ? wbuf[int'(cnt)*BURST_W +: BURST_W]
                        : '0;
   assign bus.address_o = addr;
   assign bus.read_o    = rd;
   assign bus.write_o   = wr;
   assign bus.resp_o    = resp;
   assign bus.line_o    = line;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: table vectors, corner
// sequences and randomized transactions against a line-level model.
module tb_line_burst_adaptor;
   import line_burst_adaptor_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   line_burst_adaptor_if bus ();

   line_burst_adaptor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int compared   = 0;
   int mismatched = 0;
   logic [255:0] last_line;

   typedef struct {
      string        name;
      logic         rd;
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wline;
      logic [255:0] beats;
      logic [15:0]  pat;
      int           plen;
      logic [31:0]  exp_addr;
      logic [255:0] exp_line;
      int           exp_cyc;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Cycle (counting from the request edge) in which resp_o is expected:
   // two past the index of the fourth memory acknowledge.
   function automatic int model_cyc(input logic [15:0] pat,
                                    input int plen);
      int n = 0;
      for (int i = 0; i < 64; i++) begin
         if (i >= plen || pat[i]) n++;
         if (n == 4) return i + 2;
      end
      return -1;
   endfunction

   task automatic run_txn(
      input string        name,
      input logic         rd,
      input logic         wr,
      input logic [31:0]  addr,
      input logic [255:0] wline,
      input logic [255:0] beats,
      input logic [15:0]  pat,
      input int           plen,
      input logic [31:0]  exp_addr,
      input logic [255:0] exp_line,
      input int           exp_cyc
   );
      int k = 0;
      int c = 0;
      logic ack;
      logic [255:0] tmp;
      @(negedge clk);
      bus.read_i    = rd;
      bus.write_i   = wr;
      bus.address_i = addr;
      bus.line_i    = wline;
      bus.resp_i    = 1'b0;
      while (c < 64) begin
         c++;
         @(negedge clk);
         if (bus.resp_o === 1'b1) break;
         bus.address_i = $urandom;
         bus.line_i    = {8{$urandom}};
         chk({name, ".address_o"}, 256'(bus.address_o), 256'(exp_addr));
         chk({name, ".read_o"}, 256'(bus.read_o), 256'(rd & ~wr));
         chk({name, ".write_o"}, 256'(bus.write_o), 256'(wr));
         if (wr && k < 4) begin
            tmp = wline >> (64 * k);
            chk($sformatf("%s.burst_o[%0d]", name, k),
                256'(bus.burst_o), 256'(tmp[63:0]));
         end
         ack = (c - 1 < plen) ? pat[c-1] : 1'b1;
         if (k >= 4) ack = 1'b0;
         tmp = beats >> (64 * (k % 4));
         bus.burst_i = tmp[63:0];
         bus.resp_i  = ack;
         if (ack) k++;
      end
      chk({name, ".resp_cycle"}, 256'(c), 256'(exp_cyc));
      chk({name, ".line_o"}, bus.line_o, exp_line);
      chk({name, ".done_rd_wr"},
          256'({bus.read_o, bus.write_o}), 256'(0));
      // Protocol-violating ack during DONE must be ignored.
      bus.resp_i  = 1'b1;
      bus.burst_i = {2{$urandom}};
      @(negedge clk);
      chk({name, ".resp_one_pulse"}, 256'(bus.resp_o), 256'(0));
      chk({name, ".line_after_done"}, bus.line_o, exp_line);
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      bus.resp_i  = 1'b0;
   endtask

   initial begin
      logic [255:0] l1;
      l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      tbl[0] = '{"rd_zero_wait", 1'b1, 1'b0, 32'h0000_1234, '0, l1,
                 16'h0000, 0, 32'h0000_1220, l1, 5};
      tbl[1] = '{"rd_waits", 1'b1, 1'b0, 32'h0000_1234, '0, l1,
                 16'h0069, 7, 32'h0000_1220, l1, 8};
      tbl[2] = '{"wr", 1'b0, 1'b1, 32'hABCD_EF7F,
                 {64'hD, 64'hC, 64'hB, 64'hA}, '0,
                 16'h0000, 0, 32'hABCD_EF60, l1, 5};
      tbl[3] = '{"rd_wr_both", 1'b1, 1'b1, 32'h0000_0FFF,
                 {64'hDEAD_BEEF_0000_0004, 64'hCAFE_F00D_0000_0003,
                  64'h0123_4567_89AB_0002, 64'hFEDC_BA98_7654_0001},
                 {4{64'h5A5A_5A5A_5A5A_5A5A}},
                 16'h0005, 3, 32'h0000_0FE0, l1, 6};

      rst           = 1'b1;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.address_i = '0;
      bus.line_i    = '0;
      bus.burst_i   = '0;
      bus.resp_i    = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset.read_o", 256'(bus.read_o), 256'(0));
      chk("reset.write_o", 256'(bus.write_o), 256'(0));
      chk("reset.resp_o", 256'(bus.resp_o), 256'(0));
      chk("reset.address_o", 256'(bus.address_o), 256'(0));
      chk("reset.burst_o", 256'(bus.burst_o), 256'(0));
      chk("reset.line_o", bus.line_o, 256'(0));
      rst = 1'b0;
      last_line = '0;

      for (int i = 0; i < 4; i++) begin
         run_txn(tbl[i].name, tbl[i].rd, tbl[i].wr, tbl[i].addr,
                 tbl[i].wline, tbl[i].beats, tbl[i].pat, tbl[i].plen,
                 tbl[i].exp_addr, tbl[i].exp_line, tbl[i].exp_cyc);
      end
      last_line = l1;

      // Reset after two beats of a read: abort, no resp, no stale data.
      @(negedge clk);
      bus.read_i    = 1'b1;
      bus.address_i = 32'h0000_0040;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         bus.resp_i  = 1'b1;
         bus.burst_i = 64'hBAD0_0000_0000_0000 | 64'(b);
      end
      @(negedge clk);
      bus.resp_i = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      chk("midrst.read_o", 256'(bus.read_o), 256'(0));
      chk("midrst.resp_o", 256'(bus.resp_o), 256'(0));
      chk("midrst.address_o", 256'(bus.address_o), 256'(0));
      chk("midrst.line_o", bus.line_o, 256'(0));
      rst        = 1'b0;
      bus.read_i = 1'b0;
      last_line  = {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007,
                    64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005};
      run_txn("post_rst_rd", 1'b1, 1'b0, 32'h0000_0080, '0, last_line,
              16'h0000, 0, 32'h0000_0080, last_line, 5);

      for (int t = 0; t < 24; t++) begin
         logic rd, wr;
         logic [31:0]  a;
         logic [255:0] wl, bt, exp_l;
         logic [15:0]  p;
         int           pl, kind;
         kind = $urandom_range(0, 4);
         rd   = (kind != 1);
         wr   = (kind == 1 || kind == 2);
         a    = $urandom;
         wl   = {8{$urandom}};
         bt   = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
         p    = 16'($urandom);
         pl   = $urandom_range(0, 16);
         exp_l = (rd && !wr) ? bt : last_line;
         run_txn($sformatf("rand%0d", t), rd, wr, a, wl, bt, p, pl,
                 a - (a % 32), exp_l, model_cyc(p, pl));
         last_line = exp_l;
      end

      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("idle.outs",
             256'({bus.read_o, bus.write_o, bus.resp_o}), 256'(0));
         chk("idle.line_o", bus.line_o, last_line);
         bus.resp_i  = 1'($urandom);
         bus.burst_i = {2{$urandom}};
      end
      bus.resp_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Memory-side responder for the 256-bit line interface that the eviction write buffer and caches drive: `read_i`, `write_i`, `address_i`, `line_i` in; `line_o`, `resp_o` out.
- Converts each line transaction into a 4-beat, 64-bit burst on the physical memory port.
- For reads, it assembles the beats into one line. For writes, it serialises the line into beats.
- Sits between the eviction write buffer / arbiter and main memory.

Parameters:
- LINE_W, 256, line width in bits.
- BURST_W, 64, beat width in bits. BEATS = LINE_W/BURST_W = 4, derived as a localparam.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- read_i  in  1  line read request, held until resp_o.
- write_i  in  1  line write request, held until resp_o.
- address_i  in  ADDR_W  line address; low 5 bits ignored.
- line_i  in  LINE_W  write data.
- line_o  out  LINE_W  read data, valid while resp_o=1.
- resp_o  out  1  one-cycle completion pulse.
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  ADDR_W  line-aligned burst address.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  memory beat acknowledge, one per beat.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE, beat counter=0.
  - read_o=0, write_o=0, resp_o=0.
  - address_o=0, burst_o=0, line_o=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On a clock edge with write_i=1:
    - latch `{address_i[ADDR_W-1:5],5'b0}` into address_o;
    - latch line_i into the write buffer;
    - clear the counter;
    - go to WRITE.
  - Else, on a clock edge with read_i=1: latch the address, clear the counter, go to READ.
  - If read_i and write_i are both high, write wins. This combination is illegal, but its outcome is defined.
  - resp_i in IDLE is ignored.
- READ:
  - read_o=1, held continuously until the final beat is accepted.
  - Each cycle with resp_i=1 stores burst_i into `line_o[cnt*64 +: 64]` and increments cnt.
  - Cycles with resp_i=0 are wait states: no change.
  - When resp_i=1 and cnt=3, go to DONE. read_o drops in DONE.
- WRITE:
  - write_o=1.
  - burst_o is driven combinationally from the latched line, beat `cnt` (beat 0 = bits 63:0).
  - Each resp_i=1 increments cnt. When resp_i=1 and cnt=3, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; then IDLE.
  - line_o holds the assembled line in DONE and keeps it until the next read overwrites it.
- Initiator rule: the initiator deasserts read_i/write_i in the cycle after resp_o. The adaptor samples a new request no earlier than the IDLE cycle following DONE.
- Latency:
  - With resp_i continuous from the first cycle of READ/WRITE, the request is seen at edge 0, beats are accepted at edges 1–4, and resp_o is high in cycle 5.
  - This is 6 cycles from request assertion to resp_o deassert.
  - Memory wait states add 1:1.
- address_o and the latched write line are stable for the whole transaction, even if address_i or line_i change.
- The counter is 2 bits; wrap after beat 3 is unreachable because the state leaves READ/WRITE.
- rst mid-transaction:
  - abort immediately to IDLE with all outputs at reset values;
  - a partially assembled line is discarded;
  - resp_o is not issued.
- resp_i in DONE is ignored. This is a protocol violation that must not corrupt line_o.

Decomposition:
- Shared package (cache_types or equivalent) holds:
  - LINE_W, BURST_W, ADDR_W, BEATS;
  - the adaptor state enum `{IDLE, READ, WRITE, DONE}`;
  - the line offset width constant (5).
- The block is a single module containing the FSM, beat counter, and line shift/insert register.
- No sub-module is needed. An optional `line_burst_ctrl` FSM split is permitted but not required.

Test Plan:
- Read, zero wait:
  - Stimulus: read_i=1, address_i=0x0000_1234; resp_i high 4 cycles with burst_i = 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: address_o=0x0000_1220; resp_o pulses once in cycle 5; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Read with waits:
  - Stimulus: same beats, with resp_i pattern 1,0,0,1,0,1,1.
  - Required: line_o identical to the zero-wait case; read_o held throughout; resp_o one cycle after the last beat.
- Write:
  - Stimulus: write_i=1, line_i = {64'hD, 64'hC, 64'hB, 64'hA}, resp_i continuous.
  - Required: burst_o = A, B, C, D on successive resp_i cycles; write_o drops after beat 4; resp_o one pulse.
- Simultaneous read_i=write_i=1 -> write_o asserts, read_o stays 0, and the write completes normally.
- Reset mid-read:
  - Stimulus: rst asserted after beat 2.
  - Required: next cycle read_o=0, resp_o=0, state IDLE. A subsequent full read returns correct data with no stale beats.
- Idle noise: resp_i toggling with no request -> read_o, write_o, resp_o remain 0 and line_o is unchanged.
